cp0_timer_unit: RTL

- Parametrised coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC, PRId, plus BadVAddr, Count and Compare.
- Adds a built-in Count/Compare timer interrupt, a configurable number of hardware interrupt lines, and defined exception/interrupt arbitration.
- Sits beside the M stage. It takes mtc0/mfc0 accesses, exception requests and the ERET clear, and drives the flush/redirect signals.

---
 rtl/cp0_timer_unit_pkg.sv | 26 ++
 rtl/cp0_timer_unit_if.sv | 26 ++
 rtl/cp0_timer_unit_timer.sv | 26 ++
 rtl/cp0_timer_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/cp0_timer_unit_pkg.sv
// cp0_defs: shared CP0 register indices, exception codes and SR/Cause field positions.
package cp0_defs;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_TI    = 30;
    localparam int CAUSE_BD    = 31;
endpackage

// File: rtl/cp0_timer_unit_if.sv
// cp0_timer_unit_if: M-stage access, exception and redirect signals between pipeline and CP0.
interface cp0_timer_unit_if #(parameter int NUM_HWINT = 6);
    logic [4:0]           a;
    logic [31:0]          din;
    logic                 we;
    logic [31:0]          dout;
    logic                 exc_req;
    logic [4:0]           exc_code_in;
    logic [31:0]          pc_in;
    logic                 bd_in;
    logic [31:0]          bad_vaddr_in;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 exl_clr;
    logic                 exc_now;
    logic [31:0]          epc_out;
    logic                 timer_int;

    modport master (
        output a, din, we, exc_req, exc_code_in, pc_in, bd_in, bad_vaddr_in, hw_int, exl_clr,
        input  dout, exc_now, epc_out, timer_int
    );
    modport slave (
        input  a, din, we, exc_req, exc_code_in, pc_in, bd_in, bad_vaddr_in, hw_int, exl_clr,
        output dout, exc_now, epc_out, timer_int
    );
endinterface

// File: rtl/cp0_timer_unit_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-pending flag TI.
module cp0_timer #(
    parameter bit TIMER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    always_ff @(posedge clk) begin
        if (reset || !TIMER_EN) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count   <= count_we ? din : count + 32'd1;
            compare <= compare_we ? din : compare;
            // a Compare write beats a match seen in the same cycle
            ti      <= compare_we ? 1'b0 : (ti | (count == compare));
        end
    end
endmodule

// File: rtl/cp0_timer_unit.sv
// cp0_timer_unit: CP0 register file with interrupt/exception arbitration and Count/Compare timer.
module cp0_timer_unit
    import cp0_defs::*;
#(
    parameter int          NUM_HWINT  = 6,
    parameter bit          TIMER_EN   = 1'b1,
    parameter int          TIMER_LINE = 7,
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000
) (
    input logic             clk,
    input logic             reset,
    cp0_timer_unit_if.slave bus
);
    localparam logic [5:0] TI_MASK = 6'(1) << (TIMER_LINE - 2);

    logic [5:0]  im, ip, hw6, ip_eff;
    logic        exl, ie, bd, int_req, wr;
    logic [4:0]  exc_code;
    logic [31:0] epc, bad_vaddr, count, compare;
    logic        ti;

    always_comb begin
        hw6 = '0;
        hw6[NUM_HWINT-1:0] = bus.hw_int;
    end

    assign ip_eff        = hw6 | (ti ? TI_MASK : 6'd0);
    assign int_req       = ~exl & ie & |(ip_eff & im);
    assign bus.exc_now   = int_req | (bus.exc_req & ~exl);
    assign wr            = bus.we & ~bus.exc_now & ~bus.exl_clr;
    assign bus.epc_out   = epc;
    assign bus.timer_int = ti;

    cp0_timer #(.TIMER_EN(TIMER_EN)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr && bus.a == CP0_COUNT),
        .compare_we (wr && bus.a == CP0_COMPARE),
        .din        (bus.din),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            bd        <= 1'b0;
            ip        <= '0;
            exc_code  <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else begin
            ip <= ip_eff;
            if (bus.exc_now) begin
                exl      <= 1'b1;
                bd       <= bus.bd_in;
                epc      <= bus.bd_in ? bus.pc_in - 32'd4 : bus.pc_in;
                exc_code <= int_req ? EXC_INT : bus.exc_code_in;
                if (!int_req && (bus.exc_code_in == EXC_ADEL || bus.exc_code_in == EXC_ADES))
                    bad_vaddr <= bus.bad_vaddr_in;
            end else if (bus.exl_clr) begin
                exl <= 1'b0;
            end else if (bus.we && bus.a == CP0_SR) begin
                im  <= bus.din[SR_IM_LO +: 6];
                exl <= bus.din[SR_EXL];
                ie  <= bus.din[SR_IE];
            end else if (bus.we && bus.a == CP0_EPC) begin
                epc <= {bus.din[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        case (bus.a)
            CP0_BADVADDR: bus.dout = bad_vaddr;
            CP0_COUNT:    bus.dout = count;
            CP0_COMPARE:  bus.dout = compare;
            CP0_SR:       bus.dout = {16'b0, im, 8'b0, exl, ie};
            CP0_CAUSE:    bus.dout = {bd, ti, 14'b0, ip, 3'b0, exc_code, 2'b0};
            CP0_EPC:      bus.dout = epc;
            CP0_PRID:     bus.dout = PRID_VAL;
            default:      bus.dout = '0;
        endcase
    end
endmodule
